// File: rtl/reg_file_pkg.sv
`default_nettype none
//============================================================================
// reg_file_pkg: shared state encoding and default geometry for reg_file_param
// Rev 1.0
//============================================================================
package reg_file_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int AW_DEFAULT = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_param_if.sv
`default_nettype none
//============================================================================
// reg_file_param_if: write/read/clear bus of the parametrised register file
// Rev 1.0
//============================================================================
interface reg_file_param_if
  import reg_file_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) ();

  logic          we;
  logic [AW-1:0] W_Adr;
  logic [DW-1:0] W;
  logic [AW-1:0] R_Adr;
  logic [AW-1:0] S_Adr;
  logic          clr;
  logic [DW-1:0] R;
  logic [DW-1:0] S;
  logic          busy;

  modport master (
    output we, W_Adr, W, R_Adr, S_Adr, clr,
    input  R, S, busy
  );

  modport slave (
    input  we, W_Adr, W, R_Adr, S_Adr, clr,
    output R, S, busy
  );

endinterface
`default_nettype wire

// File: rtl/addr_decoder.sv
`default_nettype none
//============================================================================
// addr_decoder: AW-bit address to one-hot select with global enable
// Rev 1.0
//============================================================================
module addr_decoder #(
  parameter int AW = 3
) (
  input  wire logic [AW-1:0]      i_addr,
  input  wire logic               i_en,
  output logic      [2**AW-1:0]   o_sel
);

  for (genvar i = 0; i < 2**AW; i++) begin : g_sel
    assign o_sel[i] = i_en && (i_addr == AW'(i));
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
//============================================================================
// reg_file_param: 1W/2R register file with bypass, optional zero r0, clear sweep
// Rev 1.0
//============================================================================
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int AW      = AW_DEFAULT,
  parameter int ZERO_R0 = 0
) (
  input  wire logic        clk,
  input  wire logic        reset,
  reg_file_param_if.slave  bus
);

  localparam int c_DEPTH   = 2**AW;
  localparam bit c_ZERO_EN = (ZERO_R0 != 0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW-1:0]       r_cnt;
  logic [AW-1:0]       w_cnt_nxt;
  logic [DW-1:0]       r_mem [c_DEPTH];

  logic                w_clearing;
  logic                w_wr_en;
  logic [AW-1:0]       w_wr_adr;
  logic [DW-1:0]       w_wr_data;
  logic [c_DEPTH-1:0]  w_wsel;
  logic                w_byp_r;
  logic                w_byp_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.clr) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == AW'(c_DEPTH - 1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_clearing = (r_state == CLEAR);
  assign bus.busy   = w_clearing;

  // The sweep owns the write port; external writes to a hardwired r0 are dropped here.
  assign w_wr_en   = w_clearing | (bus.we & ~(c_ZERO_EN & (bus.W_Adr == '0)));
  assign w_wr_adr  = w_clearing ? r_cnt : bus.W_Adr;
  assign w_wr_data = w_clearing ? '0 : bus.W;

  addr_decoder #(
    .AW (AW)
  ) u_wdec (
    .i_addr (w_wr_adr),
    .i_en   (w_wr_en),
    .o_sel  (w_wsel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < c_DEPTH; i++) begin
        if (w_wsel[i]) r_mem[i] <= w_wr_data;
      end
    end
  end

  assign w_byp_r = ~w_clearing & bus.we & (bus.W_Adr == bus.R_Adr);
  assign w_byp_s = ~w_clearing & bus.we & (bus.W_Adr == bus.S_Adr);

  // Zero-r0 masking sits after the bypass so it also overrides forwarded data.
  assign bus.R = (c_ZERO_EN && (bus.R_Adr == '0)) ? '0 :
                 w_byp_r ? bus.W : r_mem[bus.R_Adr];
  assign bus.S = (c_ZERO_EN && (bus.S_Adr == '0)) ? '0 :
                 w_byp_s ? bus.W : r_mem[bus.S_Adr];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
//============================================================================
// tb_reg_file_param: directed + random checks of two builds (ZERO_R0 = 0 / 1)
// Rev 1.0
//============================================================================
`timescale 1ns/1ps
module tb_reg_file_param;

  logic        clk;
  logic        reset;
  logic        tb_we;
  logic        tb_clr;
  logic [2:0]  tb_w_adr;
  logic [2:0]  tb_r_adr;
  logic [2:0]  tb_s_adr;
  logic [15:0] tb_w;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents per build, and position of the clear sweep (-1 = not sweeping)
  logic [15:0] m_mem [2][8];
  int          m_sweep;
  logic        last_busy0, last_busy1;

  reg_file_param_if #(.DW(16), .AW(3)) bus0 ();
  reg_file_param_if #(.DW(16), .AW(3)) bus1 ();

  assign bus0.we = tb_we;     assign bus1.we = tb_we;
  assign bus0.clr = tb_clr;   assign bus1.clr = tb_clr;
  assign bus0.W_Adr = tb_w_adr; assign bus1.W_Adr = tb_w_adr;
  assign bus0.W = tb_w;       assign bus1.W = tb_w;
  assign bus0.R_Adr = tb_r_adr; assign bus1.R_Adr = tb_r_adr;
  assign bus0.S_Adr = tb_s_adr; assign bus1.S_Adr = tb_s_adr;

  reg_file_param #(.DW(16), .AW(3), .ZERO_R0(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  reg_file_param #(.DW(16), .AW(3), .ZERO_R0(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++)
      for (int a = 0; a < 8; a++) m_mem[z][a] = 16'h0000;
    m_sweep = -1;
  endtask

  function automatic logic [15:0] exp_read(int z, logic [2:0] a);
    if (z == 1 && a == 3'd0) return 16'h0000;
    if (m_sweep < 0 && tb_we && tb_w_adr == a) return tb_w;
    return m_mem[z][a];
  endfunction

  task automatic model_edge();
    if (m_sweep < 0) begin
      for (int z = 0; z < 2; z++)
        if (tb_we && !(z == 1 && tb_w_adr == 3'd0)) m_mem[z][tb_w_adr] = tb_w;
      if (tb_clr) m_sweep = 0;
    end else begin
      for (int z = 0; z < 2; z++) m_mem[z][m_sweep] = 16'h0000;
      m_sweep++;
      if (m_sweep == 8) m_sweep = -1;
    end
  endtask

  // Check both builds against the model mid-cycle, then advance one edge.
  task automatic tick(string tag);
    @(negedge clk);
    check({tag, " busy0"}, {15'd0, bus0.busy}, {15'd0, (m_sweep >= 0)});
    check({tag, " busy1"}, {15'd0, bus1.busy}, {15'd0, (m_sweep >= 0)});
    check({tag, " R0"}, bus0.R, exp_read(0, tb_r_adr));
    check({tag, " S0"}, bus0.S, exp_read(0, tb_s_adr));
    check({tag, " R1"}, bus1.R, exp_read(1, tb_r_adr));
    check({tag, " S1"}, bus1.S, exp_read(1, tb_s_adr));
    last_busy0 = bus0.busy;
    last_busy1 = bus1.busy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_inputs(bit allow_clr);
    tb_we    = 1'($urandom % 2);
    tb_w_adr = 3'($urandom % 8);
    tb_w     = 16'($urandom);
    tb_r_adr = 3'($urandom % 8);
    tb_s_adr = 3'($urandom % 8);
    tb_clr   = allow_clr && ($urandom % 10 == 0);
  endtask

  initial begin
    int busy0_cycles;
    int busy1_cycles;

    tb_we = 0; tb_clr = 0; tb_w_adr = 0; tb_w = 0; tb_r_adr = 3'd5; tb_s_adr = 3'd2;
    reset = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    #5;
    check("reset busy0", {15'd0, bus0.busy}, 16'h0000);
    check("reset busy1", {15'd0, bus1.busy}, 16'h0000);
    check("reset R0", bus0.R, 16'h0000);
    check("reset S0", bus0.S, 16'h0000);
    check("reset R1", bus1.R, 16'h0000);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Basic write then read on both ports
    tb_we = 1; tb_w_adr = 3'd3; tb_w = 16'h1234; tick("wr3");
    tb_w_adr = 3'd7; tb_w = 16'hBEEF; tick("wr7");
    tb_we = 0; tb_r_adr = 3'd3; tb_s_adr = 3'd7; tick("rd37");
    check("rd R=1234", bus0.R, 16'h1234);
    check("rd S=BEEF", bus0.S, 16'hBEEF);

    // Same-cycle bypass on both ports
    tb_we = 1; tb_w_adr = 3'd5; tb_w = 16'hA5A5; tb_r_adr = 3'd5; tb_s_adr = 3'd5;
    #2;
    check("byp R", bus0.R, 16'hA5A5);
    check("byp S", bus0.S, 16'hA5A5);
    tick("byp");
    tb_we = 0; tb_w = 16'h0000; tick("byp after");
    check("byp stored", bus0.R, 16'hA5A5);

    for (int k = 0; k < 40; k++) begin
      rand_inputs(1'b0);
      tick("rand_a");
    end

    // Fill all entries, then sweep
    for (int i = 0; i < 8; i++) begin
      tb_we = 1; tb_w_adr = 3'(i); tb_w = 16'hFFFF; tb_r_adr = 3'(i); tb_s_adr = 3'(7 - i);
      tick("fill");
    end
    tb_we = 0; tb_clr = 1; tick("clr pulse");
    tb_clr = 0;
    busy0_cycles = 0;
    busy1_cycles = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 4) begin
        tb_we = 0;
        for (int i = 0; i < 4; i++) begin
          tb_r_adr = 3'(i); tb_s_adr = 3'(i + 4);
          #1;
          check("mid swept R0", bus0.R, 16'h0000);
          check("mid old S0", bus0.S, 16'hFFFF);
          check("mid old S1", bus1.S, 16'hFFFF);
        end
      end
      tb_we    = (m_sweep >= 0) ? 1'($urandom % 2) : 1'b0;
      tb_w_adr = 3'($urandom % 8);
      tb_w     = 16'h5A5A;
      tb_r_adr = 3'($urandom % 8);
      tb_s_adr = 3'($urandom % 8);
      tick("sweep");
      if (last_busy0) busy0_cycles++;
      if (last_busy1) busy1_cycles++;
    end
    check("busy cycles 0", 16'(busy0_cycles), 16'd8);
    check("busy cycles 1", 16'(busy1_cycles), 16'd8);
    tb_we = 0;
    for (int i = 0; i < 8; i++) begin
      tb_r_adr = 3'(i); tb_s_adr = 3'(7 - i);
      tick("post clr");
      check("post clr R0", bus0.R, 16'h0000);
    end

    // Write on the same edge that starts the sweep
    tb_we = 1; tb_w_adr = 3'd2; tb_w = 16'h0F0F; tb_clr = 1; tick("clr+wr");
    tb_we = 0; tb_clr = 0; tb_r_adr = 3'd2; tb_s_adr = 3'd2;
    for (int k = 0; k < 8; k++) tick("clr+wr sweep");
    tick("clr+wr done");
    check("clr+wr e2", bus0.R, 16'h0000);

    // Hardwired r0
    tb_we = 1; tb_w_adr = 3'd0; tb_w = 16'h7777; tb_r_adr = 3'd0; tb_s_adr = 3'd0;
    #2;
    check("z0 byp R1", bus1.R, 16'h0000);
    check("z0 byp R0", bus0.R, 16'h7777);
    tick("z0 wr");
    tb_we = 0; tick("z0 after");
    check("z0 after R1", bus1.R, 16'h0000);
    check("z0 after R0", bus0.R, 16'h7777);

    for (int k = 0; k < 60; k++) begin
      rand_inputs(1'b1);
      tick("rand_b");
    end
    tb_clr = 0; tb_we = 0;
    while (m_sweep >= 0) tick("drain");

    // Asynchronous reset in the middle of a sweep
    for (int i = 0; i < 8; i++) begin
      tb_we = 1; tb_w_adr = 3'(i); tb_w = 16'(16'h1100 + i);
      tick("refill");
    end
    tb_we = 0; tb_clr = 1; tick("clr2");
    tb_clr = 0;
    for (int k = 0; k < 3; k++) tick("sweep2");
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("arst busy0", {15'd0, bus0.busy}, 16'h0000);
    check("arst busy1", {15'd0, bus1.busy}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      tb_r_adr = 3'(i); tb_s_adr = 3'(7 - i);
      #1;
      check("arst R0", bus0.R, 16'h0000);
      check("arst S0", bus0.S, 16'h0000);
      check("arst R1", bus1.R, 16'h0000);
    end
    @(posedge clk); #1;
    check("arst hold busy0", {15'd0, bus0.busy}, 16'h0000);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rand_inputs(1'b1);
      tick("rand_c");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_param.md
# reg_file_param

Parametrised multi-port register file: DEPTH = 2**AW words of DW bits, one synchronous write port, two combinational read ports (R and S) with write-to-read bypass. It adds an optional hardwired-zero register 0 and a hardware clear sequencer that zeroes every entry, one per cycle, on request. It sits in the CPU datapath between the writeback mux and the ALU operand inputs, and is the drop-in successor of the fixed 8×16 register file.

## Interface
- DW, 16, data width in bits
- AW, 3, address width; DEPTH = 2**AW entries
- ZERO_R0, 0, when 1 entry 0 always reads 0 and writes to it are discarded
- clk  in  1  single clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- we  in  1  write enable
- W_Adr  in  AW  write address
- W  in  DW  write data
- R_Adr  in  AW  read address, port R
- S_Adr  in  AW  read address, port S
- clr  in  1  request clear sweep (single-cycle pulse or level; sampled only in IDLE)
- R  out  DW  read data, port R
- S  out  DW  read data, port S
- busy  out  1  high while clear sweep runs

## Operation
- Reset (reset=0, asynchronous): all entries 0, state IDLE, sweep counter 0, busy 0.
- States: IDLE, CLEAR.
- IDLE: if we=1, entry[W_Adr] <= W at the rising edge (discarded when ZERO_R0=1 and W_Adr=0). If clr=1 at the same edge: go to CLEAR with cnt=0; the write in that cycle is still performed.
- CLEAR: each cycle entry[cnt] <= 0, cnt <= cnt+1; when cnt = DEPTH-1 the write of entry DEPTH-1 completes and the state returns to IDLE, cnt <= 0. External we and clr are ignored throughout CLEAR.
- busy = 1 exactly while the state is CLEAR.
- Reads are combinational: R = entry[R_Adr], S = entry[S_Adr].
- Bypass: in IDLE, if we=1 and W_Adr = R_Adr, R = W in the same cycle; the same rule applies to S. Bypass is disabled in CLEAR and for address 0 when ZERO_R0=1.
- ZERO_R0=1: R/S return 0 for address 0 unconditionally.
- Reads during CLEAR return current stored contents: entries already swept read 0, the remainder read old data.
- Counter is AW bits and wraps naturally at DEPTH-1; no other arithmetic.

## Timing
- Write latency: data is visible via storage on the cycle after the edge, and via bypass in the same cycle.
- Read latency: 0 cycles (combinational from address).
- Clear sweep: exactly DEPTH cycles of busy=1, beginning the cycle after clr is sampled.
- Reset asserted mid-sweep: immediate return to IDLE, all entries 0, busy 0.
- Reset deassertion is synchronised externally; the first edge after release may accept a write.

## Structure
- Shared package reg_file_pkg: state typedef (IDLE, CLEAR) and the default DW/AW constants.
- One sub-module: addr_decoder (parametrised AW-to-DEPTH one-hot decoder with enable), used for write select.
- Storage is a DEPTH×DW register array. The read mux and bypass are implemented in the top module; there are no tri-state buses.

## Test plan
- Write/read: reset, write 0x1234→addr 3, 0xBEEF→addr 7; set R_Adr=3, S_Adr=7 → R=0x1234, S=0xBEEF.
- Bypass: we=1, W_Adr=5, W=0xA5A5, R_Adr=S_Adr=5 in the same cycle → R=S=0xA5A5 before the edge; entry 5 holds it afterwards.
- Clear sweep: fill all 8 entries with 0xFFFF, pulse clr → busy high for exactly 8 cycles. Mid-sweep at cycle 4, entries 0–3 read 0 and entries 4–7 read 0xFFFF; afterwards all entries read 0. A we pulse during the sweep has no effect.
- clr with write: same edge we=1, W_Adr=2, W=0x0F0F, clr=1 → after the sweep, entry 2 = 0.
- ZERO_R0=1 build: write 0x7777→addr 0 with R_Adr=0 → R=0 both during the cycle and after the edge.
- Async reset mid-sweep: assert reset at sweep cycle 3 between edges → busy=0 and all reads return 0 immediately.
